// File: rtl/simd_result_writer.sv
// simd_result_writer: captures one SIMD result vector and writes its lanes to memory one word per accepted write
module simd_result_writer #(
    parameter int ALUWIDTH  = 4,
    parameter int ADDRWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*ALUWIDTH-1:0] result_s,
    input  logic [ALUWIDTH-1:0]   iszero_s,
    input  logic [ALUWIDTH-1:0]   overflow_s,
    input  logic [ADDRWIDTH-1:0]  base_addr,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDRWIDTH-1:0]  mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  done,
    output logic [ALUWIDTH-1:0]   zero_mask,
    output logic [ALUWIDTH-1:0]   ovf_mask,
    output logic                  any_ovf
);
    localparam int LW = ALUWIDTH > 1 ? $clog2(ALUWIDTH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [32*ALUWIDTH-1:0] lanes_q, lanes_d;
    logic [ADDRWIDTH-1:0]   base_q, base_d;
    logic [ALUWIDTH-1:0]    zero_q, zero_d;
    logic [ALUWIDTH-1:0]    ovf_q, ovf_d;
    logic                   last;

    assign last = lane_q == LW'(ALUWIDTH - 1);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        lanes_d = lanes_q;
        base_d  = base_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid && in_ready) begin
            state_d = WRITE;
            lane_d  = '0;
            lanes_d = result_s;
            base_d  = base_addr;
            zero_d  = iszero_s;
            ovf_d   = overflow_s;
        end
        // a lane advances only when the memory accepts the current write
        if (state_q == WRITE && mem_ready) begin
            state_d = last ? DONE : WRITE;
            lane_d  = last ? lane_q : lane_q + LW'(1);
        end
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            lanes_q <= '0;
            base_q  <= '0;
            zero_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
            base_q  <= base_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = reset_n && state_q == IDLE;
    assign mem_we    = state_q == WRITE;
    assign done      = state_q == DONE;
    assign mem_addr  = base_q + ADDRWIDTH'(lane_q);
    assign mem_wdata = lanes_q[32*lane_q +: 32];
    assign zero_mask = zero_q;
    assign ovf_mask  = ovf_q;
    assign any_ovf   = |ovf_q;
endmodule

// File: tb/tb_simd_result_writer.sv
// tb_simd_result_writer: scoreboard bench for simd_result_writer with ALUWIDTH=4, ADDRWIDTH=8
module tb_simd_result_writer;
    logic         clk = 1'b0;
    logic         reset_n, in_valid, in_ready, mem_we, mem_ready, done, any_ovf;
    logic [127:0] result_s;
    logic [3:0]   iszero_s, overflow_s, zero_mask, ovf_mask;
    logic [7:0]   base_addr, mem_addr;
    logic [31:0]  mem_wdata;

    int          errors = 0, checks = 0, wr_count = 0, done_cnt = 0;
    logic [39:0] sb[$];

    simd_result_writer #(.ALUWIDTH(4), .ADDRWIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .result_s(result_s), .iszero_s(iszero_s), .overflow_s(overflow_s),
        .base_addr(base_addr), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
        .zero_mask(zero_mask), .ovf_mask(ovf_mask), .any_ovf(any_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // writes complete at the next edge when mem_we && mem_ready is seen here
    always @(negedge clk) begin
        logic [39:0] e;
        if (done) done_cnt++;
        if (mem_we && mem_ready) begin
            if (sb.size() == 0) check("extra_write", 1, 0);
            else begin
                e = sb.pop_front();
                check("wr_addr", mem_addr, e[39:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
            wr_count++;
        end else if (mem_we && sb.size() > 0) begin
            e = sb[0];
            check("stall_addr", mem_addr, e[39:32]);
            check("stall_data", mem_wdata, e[31:0]);
        end
    end

    task automatic handshake(output int iters);
        bit ok;
        ok = 0;
        iters = 0;
        while (!ok && iters < 50) begin
            @(negedge clk);
            ok = in_ready;
            iters++;
            @(posedge clk);
        end
        if (!ok) check("hs_timeout", 0, 1);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] base, input logic [127:0] data, input logic [3:0] z,
                           input logic [3:0] o, input int stall, input bit hold, input bit toggle,
                           output int hs_it, output int dlat);
        int w0, st;
        base_addr = base; result_s = data; iszero_s = z; overflow_s = o; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back({8'(base + 8'(i)), data[32*i +: 32]});
        handshake(hs_it);
        if (!hold) in_valid = 1'b0;
        w0 = wr_count; st = stall; dlat = -1;
        for (int k = 1; k <= 40 && dlat < 0; k++) begin
            if (wr_count - w0 == 1 && st > 0) begin mem_ready = 1'b0; st--; end
            else mem_ready = 1'b1;
            if (toggle) begin
                in_valid = (wr_count - w0 < 3) ? ~in_valid : 1'b0;
                result_s = {4{$urandom}}; iszero_s = ~z; overflow_s = ~o; base_addr = ~base;
            end
            @(negedge clk);
            if (k == 1) begin
                check("zero_mask", zero_mask, z);
                check("ovf_mask", ovf_mask, o);
                check("any_ovf", any_ovf, |o);
            end
            if (done) begin dlat = k; check("ready_in_done", in_ready, 0); end
            @(posedge clk); #1;
        end
        if (dlat < 0) check("done_timeout", 0, 1);
        mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int hs, dl, w0, dc;
        logic [127:0] d;
        reset_n = 0; in_valid = 0; mem_ready = 1; result_s = '0;
        iszero_s = '0; overflow_s = '0; base_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", in_ready, 0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_zero", zero_mask, 0);
        check("rst_ovf", ovf_mask, 0);
        check("rst_any_ovf", any_ovf, 0);
        @(posedge clk); #1;

        // basic write-back
        w0 = wr_count;
        run_vec(8'h10, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h0, 4'h0, 0, 0, 0, hs, dl);
        check("s1_done_lat", dl, 5);
        check("s1_writes", wr_count - w0, 4);
        @(negedge clk);
        check("s1_ready_after", in_ready, 1);
        check("s1_done_pulse", done, 0);
        @(posedge clk); #1;

        // backpressure on lane 1
        w0 = wr_count;
        run_vec(8'h10, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h0, 4'h0, 3, 0, 0, hs, dl);
        check("s2_done_lat", dl, 8);
        check("s2_writes", wr_count - w0, 4);

        // address wrap
        run_vec(8'hFE, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 4'h0, 4'h0, 0, 0, 0, hs, dl);
        check("s3_done_lat", dl, 5);

        // flags, with in_valid toggling new data during WRITE
        run_vec(8'h40, {32'h0, 32'h7FFF_FFFF, 32'h0, 32'h5}, 4'b0101, 4'b1000, 0, 0, 1, hs, dl);
        @(negedge clk);
        check("s4_zero_hold", zero_mask, 4'b0101);
        check("s4_ovf_hold", ovf_mask, 4'b1000);
        check("s4_any_hold", any_ovf, 1);
        check("s4_no_accept", in_ready, 1);
        @(posedge clk); #1;

        // reset after lane 1
        d = {32'h44, 32'h33, 32'h22, 32'h11};
        base_addr = 8'h20; result_s = d; iszero_s = 4'b0011; overflow_s = 4'b0110; in_valid = 1;
        sb.push_back({8'h20, d[31:0]});
        sb.push_back({8'h21, d[63:32]});
        handshake(hs);
        in_valid = 0; w0 = wr_count; dc = done_cnt;
        for (int k = 0; k < 20 && wr_count - w0 < 2; k++) begin @(posedge clk); #1; end
        reset_n = 0; mem_ready = 0;
        @(negedge clk);
        check("s5_ready_low", in_ready, 0);
        @(posedge clk); #1 reset_n = 1; mem_ready = 1;
        @(negedge clk);
        check("s5_mem_we", mem_we, 0);
        check("s5_done", done, 0);
        check("s5_in_ready", in_ready, 1);
        check("s5_zero", zero_mask, 0);
        check("s5_ovf", ovf_mask, 0);
        check("s5_any_ovf", any_ovf, 0);
        repeat (6) @(negedge clk);
        check("s5_writes", wr_count - w0, 2);
        check("s5_no_done", done_cnt - dc, 0);
        @(posedge clk); #1;

        // back-to-back with in_valid held high
        w0 = wr_count;
        run_vec(8'h80, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'h1, 4'h0, 0, 1, 0, hs, dl);
        check("s6a_done_lat", dl, 5);
        run_vec(8'h90, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'h2, 4'h4, 0, 0, 0, hs, dl);
        check("s6b_hs_first_idle", hs, 1);
        check("s6b_done_lat", dl, 5);
        check("s6_writes", wr_count - w0, 8);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simd_result_writer.md
# simd_result_writer

Write-back end of the SIMD datapath. It captures one packed result vector from `simdcore` (all `ALUWIDTH` lanes plus per-lane zero and overflow flags) through a valid/ready handshake. It then serializes the lanes into a 32-bit word-addressed memory write port, one lane per accepted write. This is the counterpart of the operand-loading path: operands are unpacked from memory into lanes, and this block packs lanes back into memory.

## Interface

Parameters:
- `ALUWIDTH`, default 4: number of SIMD lanes; must be at least 1.
- `ADDRWIDTH`, default 8: width of the memory word address.

Ports:
- `clk`, input, 1 bit: the single clock. All state changes on the rising edge.
- `reset_n`, input, 1 bit: reset, synchronous and active-low.
- `in_valid`, input, 1 bit: a result vector is presented.
- `in_ready`, output, 1 bit: the block can accept a vector.
- `result_s`, input, 32*ALUWIDTH bits: packed lane results; lane i is `[32*i +: 32]`.
- `iszero_s`, input, ALUWIDTH bits: per-lane zero flag.
- `overflow_s`, input, ALUWIDTH bits: per-lane overflow flag.
- `base_addr`, input, ADDRWIDTH bits: word address that receives lane 0.
- `mem_we`, output, 1 bit: write request.
- `mem_ready`, input, 1 bit: the memory accepts the write this cycle.
- `mem_addr`, output, ADDRWIDTH bits: write address.
- `mem_wdata`, output, 32 bits: write data.
- `done`, output, 1 bit: one-cycle pulse after the last lane has been written.
- `zero_mask`, output, ALUWIDTH bits: captured `iszero_s`.
- `ovf_mask`, output, ALUWIDTH bits: captured `overflow_s`.
- `any_ovf`, output, 1 bit: OR-reduction of `ovf_mask`.

## Operation

- Three-state FSM: IDLE, WRITE, DONE.

**IDLE**
- `in_ready`=1 and `mem_we`=0.
- On `in_valid && in_ready`, register the following, set lane counter=0, and go to WRITE:
  - `result_s` into the lane buffer;
  - `iszero_s` into `zero_mask`;
  - `overflow_s` into `ovf_mask`;
  - `base_addr`.
- Input buses are ignored whenever no handshake occurs.

**WRITE**
- `in_ready`=0 and `mem_we`=1.
- `mem_addr` = base + lane, truncated to ADDRWIDTH bits, so the address wraps modulo 2^ADDRWIDTH.
- `mem_wdata` = buffered lane word.
- A write completes only on a cycle where `mem_we && mem_ready`. With `mem_ready`=0, `mem_addr`, `mem_wdata` and the lane counter hold.
- On completion of lane ALUWIDTH-1, go to DONE. Otherwise increment the lane counter.

**DONE**
- `done`=1, `mem_we`=0, `in_ready`=0.
- Unconditionally return to IDLE next cycle.

**Flag outputs**
- `zero_mask`, `ovf_mask` and `any_ovf` update only at a handshake.
- They stay stable until the next handshake.

**Reset**
- Reset (`reset_n`=0 at a rising edge) forces IDLE regardless of state, including mid-WRITE. The remaining lanes are discarded and no further write is issued.
- Post-reset output values:
  - `in_ready`=1;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `done`=0;
  - `zero_mask`=0, `ovf_mask`=0, `any_ovf`=0.
- `in_ready` is 0 while `reset_n` is low.

**Outputs outside WRITE**
- `mem_addr` and `mem_wdata` hold their last values; they are don't-care.
- The bench must check them only while `mem_we`=1.

## Timing

- Handshake at edge N: first write is presented in cycle N+1.
- With no stalls, lane k is written at edge N+1+k. `done` is high in cycle N+ALUWIDTH+1, and `in_ready` returns to 1 in cycle N+ALUWIDTH+2.
- Throughput is one vector per ALUWIDTH+2 cycles, plus one cycle per stall cycle.
- `in_ready` is a function of state only, with no combinational path from `in_valid`. `mem_we`, `done` and `in_ready` are state-decoded.
- `in_valid` held high across DONE is not accepted until IDLE. The source must hold the vector until it sees `in_ready`.

## Test plan

1. **Basic write-back.** Setup: ALUWIDTH=4, `base_addr`=0x10, lanes {0x1, 0x2, 0x3, 0x4}, `mem_ready`=1. Required response:
   - writes (0x10, 0x1), (0x11, 0x2), (0x12, 0x3), (0x13, 0x4) on 4 consecutive edges;
   - `done` high exactly one cycle after the last write;
   - `in_ready` high the cycle after that.
2. **Backpressure.** Setup: same vector, with `mem_ready` held 0 for 3 cycles while lane 1 is presented. Required response:
   - `mem_addr`=0x11 and `mem_wdata`=0x2 stable through the stall;
   - exactly 4 writes total, no duplicates;
   - `done` 3 cycles later than in scenario 1.
3. **Address wrap.** Setup: ADDRWIDTH=8, `base_addr`=0xFE. Required response: addresses 0xFE, 0xFF, 0x00, 0x01.
4. **Flags.** Setup: `iszero_s`=4'b0101, `overflow_s`=4'b1000. Required response:
   - `zero_mask`=0101, `ovf_mask`=1000 and `any_ovf`=1 from the cycle after the handshake;
   - unchanged while `in_valid` toggles with new data during WRITE.
5. **Reset mid-operation.** Setup: assert `reset_n`=0 for one edge after lane 1 is written. Required response:
   - no further `mem_we`;
   - `done` never pulses;
   - all outputs at reset values;
   - `in_ready`=1 on the first cycle after release.
6. **Back-to-back vectors.** Setup: `in_valid` held high with vector A and then vector B. Required response:
   - B is accepted only in IDLE after A's `done`;
   - 8 writes total, in order, with no overlap between A and B.
